// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline widths, constants and the fetch FSM encoding
package pipeline_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, KILL = 2'd2} fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry holding buffer for a response that arrives while ID is stalled
module fetch_buf
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  logic            rd,
    input  logic            clr,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc <= '0;
            instr <= NOP_INSTR;
        end else begin
            valid <= !clr && (wr || (valid && !rd));
            if (wr && !clr) begin
                pc <= wr_pc;
                instr <= wr_instr;
            end
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch unit with one outstanding imem request, redirect kill and IF/ID register
// Optional FETCH_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hazard,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);
    fetch_state_t state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, buf_pc, buf_instr;
    logic buf_valid, accept, deliver, buf_wr, buf_rd;

    assign imem_req = rst_n && state == FETCH && !buf_valid && !redirect_valid;
    assign imem_addr = pc;
    assign accept = imem_req && imem_ready;
    assign deliver = state == WAIT && imem_rvalid && !redirect_valid;
    assign buf_wr = !redirect_valid && hazard && deliver;
    assign buf_rd = !redirect_valid && !hazard && buf_valid;
    assign id_rs1 = id_instr[19:15];
    assign id_rs2 = id_instr[24:20];

    always_comb begin
        state_nx = state;
        pc_nx = redirect_valid ? redirect_pc : pc;
        case (state)
            FETCH: begin
                state_nx = accept ? WAIT : FETCH;
                pc_nx = accept ? pc + PC_INC : pc_nx;
            end
            WAIT: state_nx = imem_rvalid ? FETCH : redirect_valid ? KILL : WAIT;
            KILL: state_nx = imem_rvalid ? FETCH : KILL;
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
        end else begin
            state <= state_nx;
            pc <= pc_nx;
        end
    end

    // pc already points past the outstanding request, so the delivered pc is pc-4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc <= '0;
            id_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (!hazard) begin
            id_valid <= buf_valid || deliver;
            if (buf_valid) begin
                id_pc <= buf_pc;
                id_instr <= buf_instr;
            end else if (deliver) begin
                id_pc <= pc - PC_INC;
                id_instr <= imem_rdata;
            end
        end
    end

    fetch_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (buf_wr),
        .rd       (buf_rd),
        .clr      (redirect_valid),
        .wr_pc    (pc - PC_INC),
        .wr_instr (imem_rdata),
        .valid    (buf_valid),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {31'd0, hazard};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, redirect_valid};
        end
    end
`endif
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC of the first fetch after reset.
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset), in that order.
REQ-003 SHALL have hazard (in, 1): load-use stall from the hazard unit; holds the IF/ID register.
REQ-004 SHALL have redirect_valid (in, 1) and redirect_pc (in, 32): taken branch or jump from EX.
REQ-005 SHALL have imem_req (out, 1), imem_addr (out, 32) and imem_ready (in, 1): request handshake; a request is accepted when imem_req && imem_ready.
REQ-006 SHALL have imem_rvalid (in, 1) and imem_rdata (in, 32): response, at least 1 cycle after acceptance.
REQ-007 SHALL have id_valid (out, 1), id_pc (out, 32) and id_instr (out, 32): IF/ID register.
REQ-008 SHALL have id_rs1 (out, 5) = id_instr[19:15] and id_rs2 (out, 5) = id_instr[24:20], for the hazard unit.

Function
REQ-009 SHALL have FSM states FETCH, WAIT and KILL, with at most one outstanding request.
REQ-010 SHALL drive imem_req = (state==FETCH) && !buf_valid && !redirect_valid, and imem_addr = pc.
REQ-011 SHALL, on FETCH with acceptance, set pc <= pc+4 (wrapping modulo 2^32) and go to WAIT.
REQ-012 SHALL, on FETCH with redirect_valid, set pc <= redirect_pc and issue no request that cycle.
REQ-013 SHALL, on WAIT with imem_rvalid and no redirect, deliver {pc-4, imem_rdata} and go to FETCH.
REQ-014 SHALL, on WAIT with redirect_valid and !imem_rvalid, set pc <= redirect_pc and go to KILL.
REQ-015 SHALL, on WAIT with redirect_valid and imem_rvalid in the same cycle, discard the response, set pc <= redirect_pc and go to FETCH.
REQ-016 SHALL, on KILL, discard the next imem_rvalid response and go to FETCH; a redirect in KILL SHALL update pc only.
REQ-017 SHALL ignore imem_rvalid while in FETCH.
REQ-018 SHALL give redirect_valid priority: id_valid <= 0, buf_valid <= 0, regardless of hazard.
REQ-019 SHALL, when hazard=1 and no redirect, hold id_* unchanged and write a delivered response into the one-entry buffer (buf_valid <= 1).
REQ-020 SHALL, when hazard=0 and no redirect, load id_* from the buffer if buf_valid (then clear it), else from a delivered response (id_valid <= 1), else set id_valid <= 0.
REQ-021 SHALL guarantee buf_valid=1 implies state==FETCH with no request outstanding (imem_req is blocked while the buffer is full).
REQ-022 SHALL have fetch-to-ID latency of 1 cycle after imem_rvalid; with a 1-cycle memory and no stalls, throughput is 1 instruction per 2 cycles.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously set pc=RESET_PC, state=FETCH, buf_valid=0, id_valid=0, id_pc=0 and id_instr=32'h0000_0013 (NOP), and force imem_req=0.
REQ-024 SHALL, on reset asserted mid-request, return to FETCH; any stale response SHALL be dropped by REQ-017.

Configuration
REQ-025 SHALL, with FETCH_PERF_CNT_EN defined, add outputs perf_stall_cnt (out, 32) and perf_flush_cnt (out, 32).
REQ-026 SHALL increment perf_stall_cnt on each hazard=1 cycle and perf_flush_cnt on each redirect_valid=1 cycle; both reset to 0 and wrap.
REQ-027 SHALL, without FETCH_PERF_CNT_EN, omit the perf ports and counter logic entirely.

Structure
REQ-028 SHALL take from shared package pipeline_pkg: XLEN=32, PC_INC=4, NOP_INSTR=32'h0000_0013, and the fetch state encoding.
REQ-029 SHALL implement the one-entry holding buffer as sub-module fetch_buf (write, read, clear, valid, pc/instr data).

Verification
REQ-030 SHALL cover reset release with RESET_PC=32'h100 and a 1-cycle memory: imem_addr 0x100, 0x104, 0x108 issued; id_pc follows with id_valid pulses.
REQ-031 SHALL cover hazard=1 for 3 cycles while the instruction at 0x104 is in ID: id_pc holds 0x104, the next response is buffered, and imem_req stays low until hazard drops, then 0x108 enters ID the next cycle.
REQ-032 SHALL cover redirect_valid with redirect_pc=0x200 in WAIT without rvalid: state goes to KILL, the stale response is not delivered to ID, and the next imem_addr is 0x200.
REQ-033 SHALL cover redirect and rvalid in the same cycle together with hazard=1: id_valid=0, the buffer is cleared, and the next fetch is 0x200.
REQ-034 SHALL cover pc=32'hFFFF_FFFC accepted: pc wraps to 0x0.
REQ-035 SHALL cover rst_n pulsed low in WAIT: imem_req=0 during reset, a late rvalid is ignored, and fetch restarts at RESET_PC.
